prog_loader: RTL
================

# prog_loader

Byte-stream program loader that fills the CPU's instruction RAM image and holds the CPU in reset until a complete, checksummed program has arrived. It sits between the host-side byte link and the `cpu` top level. It drives the flattened `ram` bus that `cpu` fetches from, and its `cpu_reset` output feeds the CPU's `reset` input. It is the writer for the instruction words the CPU decoder reads.

## Interface
- `RAM_SIZE`, default 256: number of 32-bit words in the RAM image. Legal range is 1..256.
- `clk`  input  1: system clock; all state updates on its rising edge.
- `reset`  input  1: asynchronous, active-high reset.
- `byte_in`  input  8: incoming stream byte.
- `byte_valid`  input  1: `byte_in` is valid this cycle.
- `byte_ready`  output  1: loader accepts a byte this cycle.
- `ram`  output  RAM_SIZE*32: RAM image. Word k occupies bits [32k+31:32k].
- `cpu_reset`  output  1: holds the CPU in reset while high.
- `load_count`  output  8: words written in the current frame.
- `done`  output  1: program loaded successfully.
- `error`  output  1: last frame was rejected.

## Operation
- **Handshake**
  - A byte is consumed on a rising edge where `byte_valid && byte_ready`.
  - `byte_ready` is decoded combinationally from state: 1 in SYNC, LEN, DATA, CSUM and ERR; 0 in DONE.
- **Frame format**
  - Header byte 0xA5.
  - Length byte N, the word count.
  - N×4 payload bytes. Each word is sent big-endian: the first byte goes to bits [31:24] (condition/supergroup byte), the last byte to bits [7:0] (arg2).
  - One checksum byte.
- **Checksum rule**
  - The 8-bit sum mod 256 of N, all payload bytes and the checksum byte must equal 0x00.
  - The header byte is excluded from the sum.
- **States**
  - SYNC: accepted bytes other than 0xA5 are discarded. 0xA5 → LEN, with the running sum, byte index and `load_count` cleared.
  - LEN:
    - If N==0 or N>RAM_SIZE, → ERR.
    - Otherwise latch N, sum ← N, → DATA.
  - DATA:
    - Each accepted byte shifts into a 32-bit assembly register; the 2-bit byte index increments; sum += byte.
    - On the 4th byte, write the assembled word to `ram[load_count]` on that same edge and increment `load_count`.
    - When `load_count` reaches N, → CSUM.
  - CSUM: add the byte to the sum. Result 0 → DONE; otherwise → ERR.
  - DONE: terminal until `reset`. No bytes are accepted.
  - ERR:
    - `error`=1 and `cpu_reset` stays 1.
    - Non-0xA5 bytes are discarded.
    - 0xA5 → LEN and clears `error`.
- **RAM contents**
  - Cleared to all zero on reset. An all-zero word is an unconditional NOP.
  - A frame overwrites only words 0..N-1. Other words keep their prior value.
  - No rollback on ERR: words already written stay written.

## Timing
- **Reset values:** state SYNC, `ram`=0, `cpu_reset`=1, `done`=0, `error`=0, `load_count`=0, `byte_ready`=1.
- `done` rises and `cpu_reset` falls (both registered) on the edge that accepts a valid checksum byte. The CPU therefore leaves reset on the next cycle.
- `error` is set on the edge that accepts a bad length or a bad checksum byte.
- Word-write latency: the word is visible on `ram` immediately after the edge that accepts its 4th byte.
- Gaps (`byte_valid`=0) may occur anywhere. State, sum and index hold unchanged through a gap.
- Asserting `reset` mid-frame immediately returns everything to reset values, including clearing `ram`. There is no partial-frame recovery.
- Throughput: one byte per cycle maximum. A frame takes 3+4N accepted bytes.

## Test plan
- **Reset:** assert `reset` asynchronously mid-cycle. Require `cpu_reset`=1, `done`=0, `error`=0, `load_count`=0, `byte_ready`=1 and `ram`=0 with no clock edge.
- **Good load:** back-to-back stream A5 02 00 04 01 07 00 01 00 00 F1.
  - Require `ram[31:0]`=0x00040107 and `ram[63:32]`=0x00010000.
  - Require `load_count`=2, and `done`=1 and `cpu_reset`=0 after the F1 edge.
  - Require `byte_ready`=0 afterwards.
- **Bad checksum:** same frame ending in F2.
  - Require `error`=1 and `cpu_reset`=1, with words 0..1 written as above.
  - A following correct frame → `done`=1 and `error`=0.
- **Sync:** send 00 FF 5A before the good frame. The leading bytes are consumed with no state change, and the frame loads identically.
- **Length errors:** A5 00 → `error`=1 after the length byte. With RAM_SIZE=4, A5 05 → `error`=1.
- **Gaps and reset mid-frame:**
  - Good frame with `byte_valid` deasserted for 3 cycles between every byte → same result as the back-to-back case.
  - Assert `reset` after 6 payload bytes → all outputs and `ram` return to reset values.

Source files
------------

// File: rtl/prog_loader.sv
// prog_loader: byte-stream program loader for the CPU instruction RAM image.
// Receives frames of the form A5, N, N x 4 big-endian word bytes, checksum,
// writes words 0..N-1 of the RAM image and releases the CPU from reset once
// a frame with a valid checksum has arrived.
//
// Ports:
//   clk         system clock, rising edge
//   reset       asynchronous active-high reset
//   byte_in     incoming stream byte
//   byte_valid  byte_in valid this cycle
//   byte_ready  loader accepts a byte this cycle (decoded from state)
//   ram         RAM image, word k at [32k+31:32k]
//   cpu_reset   holds the CPU in reset while high
//   load_count  words written in the current frame
//   done        program loaded successfully (terminal until reset)
//   error       last frame was rejected
module prog_loader #(
  parameter int unsigned RAM_SIZE = 256
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [7:0]              byte_in,
  input  logic                    byte_valid,
  output logic                    byte_ready,
  output logic [RAM_SIZE*32-1:0]  ram,
  output logic                    cpu_reset,
  output logic [7:0]              load_count,
  output logic                    done,
  output logic                    error
);

  localparam int unsigned RAM_W   = RAM_SIZE * 32;
  localparam logic [8:0]  MAX_LEN = 9'(RAM_SIZE);
  localparam logic [7:0]  HDR     = 8'hA5;

  typedef enum logic [2:0] {
    S_SYNC,
    S_LEN,
    S_DATA,
    S_CSUM,
    S_DONE,
    S_ERR
  } state_t;

  state_t            r_state;
  logic [7:0]        r_sum;
  logic [1:0]        r_idx;
  logic [23:0]       r_asm;
  logic [7:0]        r_len;
  logic [7:0]        r_count;
  logic              r_done;
  logic              r_error;
  logic              r_cpu_reset;
  logic [RAM_W-1:0]  r_ram;

  state_t            w_state_nxt;
  logic [7:0]        w_sum_nxt;
  logic [1:0]        w_idx_nxt;
  logic [23:0]       w_asm_nxt;
  logic [7:0]        w_len_nxt;
  logic [7:0]        w_count_nxt;
  logic              w_done_nxt;
  logic              w_error_nxt;
  logic              w_cpu_reset_nxt;
  logic              w_wr_en;
  logic [31:0]       w_wr_word;
  logic              w_ready;
  logic              w_accept;
  logic [7:0]        w_sum_add;
  logic [7:0]        w_count_inc;

  // Only the terminal state refuses bytes.
  assign w_ready     = (r_state != S_DONE);
  assign w_accept    = byte_valid && w_ready;
  assign w_sum_add   = r_sum + byte_in;
  assign w_count_inc = r_count + 8'd1;
  // The first three bytes of a word sit in r_asm; the fourth completes it.
  assign w_wr_word   = {r_asm, byte_in};

  // State register and frame datapath registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= S_SYNC;
      r_sum       <= '0;
      r_idx       <= '0;
      r_asm       <= '0;
      r_len       <= '0;
      r_count     <= '0;
      r_done      <= 1'b0;
      r_error     <= 1'b0;
      r_cpu_reset <= 1'b1;
    end else begin
      r_state     <= w_state_nxt;
      r_sum       <= w_sum_nxt;
      r_idx       <= w_idx_nxt;
      r_asm       <= w_asm_nxt;
      r_len       <= w_len_nxt;
      r_count     <= w_count_nxt;
      r_done      <= w_done_nxt;
      r_error     <= w_error_nxt;
      r_cpu_reset <= w_cpu_reset_nxt;
    end
  end

  // Next-state and next-value decode; nothing moves without an accepted byte.
  always_comb begin
    w_state_nxt     = r_state;
    w_sum_nxt       = r_sum;
    w_idx_nxt       = r_idx;
    w_asm_nxt       = r_asm;
    w_len_nxt       = r_len;
    w_count_nxt     = r_count;
    w_done_nxt      = r_done;
    w_error_nxt     = r_error;
    w_cpu_reset_nxt = r_cpu_reset;
    w_wr_en         = 1'b0;

    if (w_accept) begin
      case (r_state)
        S_SYNC, S_ERR: begin
          if (byte_in == HDR) begin
            w_state_nxt = S_LEN;
            w_sum_nxt   = '0;
            w_idx_nxt   = '0;
            w_count_nxt = '0;
            w_error_nxt = 1'b0;
          end
        end
        S_LEN: begin
          if ((byte_in == 8'd0) || ({1'b0, byte_in} > MAX_LEN)) begin
            w_state_nxt = S_ERR;
            w_error_nxt = 1'b1;
          end else begin
            w_len_nxt   = byte_in;
            w_sum_nxt   = byte_in;
            w_state_nxt = S_DATA;
          end
        end
        S_DATA: begin
          w_sum_nxt = w_sum_add;
          w_idx_nxt = r_idx + 2'd1;
          w_asm_nxt = {r_asm[15:0], byte_in};
          if (r_idx == 2'd3) begin
            w_wr_en     = 1'b1;
            w_count_nxt = w_count_inc;
            if (w_count_inc == r_len) begin
              w_state_nxt = S_CSUM;
            end
          end
        end
        S_CSUM: begin
          w_sum_nxt = w_sum_add;
          if (w_sum_add == 8'd0) begin
            w_state_nxt     = S_DONE;
            w_done_nxt      = 1'b1;
            w_cpu_reset_nxt = 1'b0;
          end else begin
            w_state_nxt = S_ERR;
            w_error_nxt = 1'b1;
          end
        end
        S_DONE: begin
          w_state_nxt = S_DONE;
        end
        default: begin
          w_state_nxt = S_SYNC;
        end
      endcase
    end
  end

  // RAM image: one word written per completed payload word, no rollback.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ram <= '0;
    end else if (w_wr_en) begin
      for (int unsigned k = 0; k < RAM_SIZE; k++) begin
        if (r_count == 8'(k)) begin
          r_ram[32*k +: 32] <= w_wr_word;
        end
      end
    end
  end

  assign byte_ready = w_ready;
  assign ram        = r_ram;
  assign cpu_reset  = r_cpu_reset;
  assign load_count = r_count;
  assign done       = r_done;
  assign error      = r_error;

endmodule
